// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad scanner and its 7-segment display.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN      = 2'd0,
        DEB_PRESS = 2'd1,
        HELD      = 2'd2,
        DEB_REL   = 2'd3
    } scan_state_t;

    // All segments off (active-low), decimal point off.
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Width of a key code for n keys; never narrower than one bit.
    function automatic int key_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Display entry {blank, hex[3:0]} to active-low segments {dp,g,f,e,d,c,b,a}.
    function automatic logic [7:0] hex_to_seg(input logic [4:0] ent);
        logic [7:0] s;
        if (ent[4]) begin
            s = SEG_BLANK;
        end else begin
            case (ent[3:0])
                4'h0:    s = 8'hC0;
                4'h1:    s = 8'hF9;
                4'h2:    s = 8'hA4;
                4'h3:    s = 8'hB0;
                4'h4:    s = 8'h99;
                4'h5:    s = 8'h92;
                4'h6:    s = 8'h82;
                4'h7:    s = 8'hF8;
                4'h8:    s = 8'h80;
                4'h9:    s = 8'h90;
                4'hA:    s = 8'h88;
                4'hB:    s = 8'h83;
                4'hC:    s = 8'hC6;
                4'hD:    s = 8'hA1;
                4'hE:    s = 8'h86;
                default: s = 8'h8E;
            endcase
        end
        return s;
    endfunction

endpackage

// File: rtl/seg7_mux.sv
// Time-multiplexed common-anode display driver: rotates one enabled digit
// through the flattened buffer and presents its glyph on seg in the same cycle.
module seg7_mux
    import keypad_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 5000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DIGITS*5-1:0] disp_buf,
    output logic [DIGITS-1:0]   digit,
    output logic [7:0]          seg
);

    localparam int SW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    logic [CW-1:0] ref_cnt;
    logic [SW-1:0] sel;
    logic [SW-1:0] sel_nxt;
    logic          ref_tc;

    assign ref_tc = (ref_cnt == CW'(REFRESH_DIV - 1));

    // Next digit to enable: advance only at the end of a refresh slot.
    always_comb begin
        sel_nxt = sel;
        if (ref_tc) begin
            sel_nxt = (sel == SW'(DIGITS - 1)) ? '0 : sel + 1'b1;
        end
    end

    // digit and seg are registered from the same select so they never skew.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ref_cnt <= '0;
            sel     <= '0;
            digit   <= ~DIGITS'(1);
            seg     <= SEG_BLANK;
        end else begin
            ref_cnt <= ref_tc ? '0 : ref_cnt + 1'b1;
            sel     <= sel_nxt;
            digit   <= ~(DIGITS'(1) << sel_nxt);
            seg     <= hex_to_seg(disp_buf[sel_nxt*5 +: 5]);
        end
    end

endmodule

// File: rtl/keypad_scan_disp.sv
// Matrix keypad scanner with press/release debounce feeding a shifting hex
// display buffer shown on a multiplexed 7-segment display.
//
//   state     | meaning
//   ----------+---------------------------------------------------------
//   SCAN      | drive one row per SCAN_DIV dwell, look for any closed column
//   DEB_PRESS | row held, column pattern must stay identical DEBOUNCE_CNT cycles
//   HELD      | key accepted, wait for every column to open
//   DEB_REL   | all columns open must persist DEBOUNCE_CNT cycles
module keypad_scan_disp
    import keypad_pkg::*;
#(
    parameter int ROWS         = 4,
    parameter int COLS         = 4,
    parameter int DIGITS       = 4,
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 20000,
    parameter int REFRESH_DIV  = 5000,
    localparam int KW          = key_width(ROWS * COLS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [COLS-1:0]   vl,
    input  logic              clr,
    output logic [ROWS-1:0]   hl,
    output logic [KW-1:0]     key_code,
    output logic              key_valid,
    output logic [DIGITS-1:0] digit,
    output logic [7:0]        seg
);

    localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CLW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int SCW = $clog2(SCAN_DIV);
    localparam int DW  = $clog2(DEBOUNCE_CNT);

    logic [COLS-1:0]     vl_m;
    logic [COLS-1:0]     vl_s;
    logic [COLS-1:0]     pat;
    scan_state_t         state;
    logic [RW-1:0]       row;
    logic [RW-1:0]       row_inc;
    logic [CLW-1:0]      col;
    logic [CLW-1:0]      low_col;
    logic [SCW-1:0]      scan_cnt;
    logic [DW-1:0]       deb_cnt;
    logic                all_open;
    logic [3:0]          code_lo;
    logic [DIGITS*5-1:0] disp_buf;
    logic [DIGITS*5-1:0] buf_shift;

    assign all_open = &vl_s;
    assign row_inc  = (row == RW'(ROWS - 1)) ? '0 : row + 1'b1;
    // Codes beyond 15 only show their low nibble.
    assign code_lo  = 4'(key_code);

    // Column inputs come straight from the pins; bring them into clk domain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vl_m <= '1;
            vl_s <= '1;
        end else begin
            vl_m <= vl;
            vl_s <= vl_m;
        end
    end

    // Lowest closed column wins when several keys share the driven row.
    always_comb begin
        low_col = '0;
        for (int c = COLS - 1; c >= 0; c--) begin
            if (!vl_s[c]) low_col = CLW'(c);
        end
    end

    // Scan / debounce FSM; the row stays driven from detection until release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= SCAN;
            row       <= '0;
            hl        <= ~ROWS'(1);
            scan_cnt  <= '0;
            deb_cnt   <= '0;
            col       <= '0;
            pat       <= '1;
            key_code  <= '0;
            key_valid <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            case (state)
                SCAN: begin
                    if (scan_cnt == SCW'(SCAN_DIV - 1)) begin
                        scan_cnt <= '0;
                        if (all_open) begin
                            row <= row_inc;
                            hl  <= ~(ROWS'(1) << row_inc);
                        end else begin
                            col     <= low_col;
                            pat     <= vl_s;
                            deb_cnt <= '0;
                            state   <= DEB_PRESS;
                        end
                    end else begin
                        scan_cnt <= scan_cnt + 1'b1;
                    end
                end
                DEB_PRESS: begin
                    if (vl_s != pat) begin
                        deb_cnt <= '0;
                        row     <= row_inc;
                        hl      <= ~(ROWS'(1) << row_inc);
                        state   <= SCAN;
                    end else if (deb_cnt == DW'(DEBOUNCE_CNT - 1)) begin
                        deb_cnt   <= '0;
                        key_code  <= KW'(int'(row) * COLS + int'(col));
                        key_valid <= 1'b1;
                        state     <= HELD;
                    end else begin
                        deb_cnt <= deb_cnt + 1'b1;
                    end
                end
                HELD: begin
                    if (all_open) begin
                        deb_cnt <= '0;
                        state   <= DEB_REL;
                    end
                end
                DEB_REL: begin
                    if (!all_open) begin
                        deb_cnt <= '0;
                        state   <= HELD;
                    end else if (deb_cnt == DW'(DEBOUNCE_CNT - 1)) begin
                        deb_cnt <= '0;
                        row     <= row_inc;
                        hl      <= ~(ROWS'(1) << row_inc);
                        state   <= SCAN;
                    end else begin
                        deb_cnt <= deb_cnt + 1'b1;
                    end
                end
                default: state <= SCAN;
            endcase
        end
    end

    if (DIGITS > 1) begin : g_shift
        assign buf_shift = {disp_buf[DIGITS*5-6:0], 1'b0, code_lo};
    end else begin : g_single
        assign buf_shift = {1'b0, code_lo};
    end

    // New key enters at the rightmost digit; clear takes priority over a new key.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            disp_buf <= {DIGITS{5'h10}};
        end else if (clr) begin
            disp_buf <= {DIGITS{5'h10}};
        end else if (key_valid) begin
            disp_buf <= buf_shift;
        end
    end

    seg7_mux #(
        .DIGITS      (DIGITS),
        .REFRESH_DIV (REFRESH_DIV)
    ) u_seg7_mux (
        .clk      (clk),
        .rst      (rst),
        .disp_buf (disp_buf),
        .digit    (digit),
        .seg      (seg)
    );

endmodule

// File: tb/tb_keypad_scan_disp.sv
// Bench for keypad_scan_disp: a behavioural keypad drives vl from hl, key
// events are checked against a queue of expected codes, display read per digit.
module tb_keypad_scan_disp;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clr = 1'b0;
    logic [3:0] vl;
    logic [3:0] hl;
    logic [3:0] key_code;
    logic       key_valid;
    logic [3:0] digit;
    logic [7:0] seg;

    bit         pressed [16];
    bit         force_en = 1'b0;
    logic [3:0] force_vl = 4'hF;

    int total = 0;
    int bad = 0;
    int ev_cnt = 0;
    int exp_q[$];
    bit kv_prev = 1'b0;

    logic [7:0] glyph [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    keypad_scan_disp #(
        .ROWS(4), .COLS(4), .DIGITS(4),
        .SCAN_DIV(4), .DEBOUNCE_CNT(3), .REFRESH_DIV(2)
    ) dut (
        .clk(clk), .rst(rst), .vl(vl), .clr(clr), .hl(hl),
        .key_code(key_code), .key_valid(key_valid), .digit(digit), .seg(seg)
    );

    always #5 clk = ~clk;

    // Keypad model: a closed key pulls its column low while its row is driven.
    always_comb begin
        vl = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && hl[r] === 1'b0) vl[c] = 1'b0;
        if (force_en) vl = force_vl;
    end

    // Scoreboard side: every key_valid must match the oldest expected code.
    always @(negedge clk) begin
        if (rst === 1'b1 && key_valid === 1'b1) begin
            ev_cnt++;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_event key_code=%0d expected no event", key_code);
            end else begin
                int e;
                e = exp_q.pop_front();
                if (key_code !== 4'(e)) begin
                    bad++;
                    $display("FAIL event_code got=%0d expected=%0d", key_code, e);
                end
            end
            if (kv_prev) begin
                total++;
                bad++;
                $display("FAIL pulse_width key_valid high=2 cycles expected=1");
            end
        end
        kv_prev = (key_valid === 1'b1);
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic get_seg(input int idx, output logic [7:0] s, output bit found);
        found = 1'b0;
        s = 8'hxx;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            if (digit === ~(4'b0001 << idx)) begin
                s = seg;
                found = 1'b1;
            end
        end
    endtask

    task automatic wait_event(input int prev, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 100 && !ok; k++) begin
            @(negedge clk);
            if (ev_cnt > prev) ok = 1'b1;
        end
    endtask

    task automatic press_release(input int code, output bit ok);
        int prev;
        prev = ev_cnt;
        exp_q.push_back(code);
        pressed[code] = 1'b1;
        wait_event(prev, ok);
        pressed[code] = 1'b0;
        repeat (20) @(negedge clk);
    endtask

    task automatic test_reset;
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (hl !== 4'b1110) begin bad++; $display("FAIL reset_hl got=%b expected=1110", hl); end
        total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL reset_kv got=%b expected=0", key_valid); end
        total++; if (key_code !== 4'd0) begin bad++; $display("FAIL reset_code got=%0d expected=0", key_code); end
        total++; if (digit !== 4'b1110) begin bad++; $display("FAIL reset_digit got=%b expected=1110", digit); end
        total++; if (seg !== 8'hFF) begin bad++; $display("FAIL reset_seg got=%h expected=ff", seg); end
        rst = 1'b1;
    endtask

    task automatic test_idle_scan;
        bit found;
        logic [7:0] s;
        logic [3:0] e;
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            @(negedge clk);
            if (hl === 4'b1101) found = 1'b1;
        end
        total++; if (!found) begin bad++; $display("FAIL idle_first_step got=%b expected=1101", hl); end
        for (int k = 0; k < 16; k++) begin
            if (k > 0) @(negedge clk);
            e = ~(4'b0001 << ((1 + k / 4) % 4));
            total++;
            if (hl !== e) begin bad++; $display("FAIL idle_hl cycle=%0d got=%b expected=%b", k, hl, e); end
        end
        for (int i = 0; i < 4; i++) begin
            get_seg(i, s, found);
            total++;
            if (!found || s !== 8'hFF) begin bad++; $display("FAIL idle_seg digit=%0d got=%h expected=ff", i, s); end
        end
    endtask

    task automatic test_single_press;
        int prev;
        bit ok;
        logic [7:0] s;
        prev = ev_cnt;
        exp_q.push_back(9);
        pressed[9] = 1'b1;
        wait_event(prev, ok);
        total++; if (!ok) begin bad++; $display("FAIL press9_timeout got=none expected=event"); end
        repeat (5) @(negedge clk);
        total++; if (hl !== 4'b1011) begin bad++; $display("FAIL press9_held_hl got=%b expected=1011", hl); end
        pressed[9] = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (hl !== 4'b1011) begin bad++; $display("FAIL press9_release_hl got=%b expected=1011", hl); end
        repeat (20) @(negedge clk);
        total++; if (ev_cnt !== prev + 1) begin bad++; $display("FAIL press9_count got=%0d expected=%0d", ev_cnt - prev, 1); end
        get_seg(0, s, ok);
        total++; if (!ok || s !== 8'h90) begin bad++; $display("FAIL press9_seg got=%h expected=90", s); end
    endtask

    task automatic test_glitch;
        logic [3:0] cur;
        bit found;
        int r;
        @(negedge clk);
        cur = hl;
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            @(negedge clk);
            if (hl !== cur) found = 1'b1;
        end
        total++; if (!found) begin bad++; $display("FAIL glitch_sync got=%b expected=row change", hl); end
        r = 0;
        for (int i = 0; i < 4; i++) if (hl[i] === 1'b0) r = i;
        @(negedge clk);
        force_vl = 4'b1110;
        force_en = 1'b1;
        repeat (2) @(negedge clk);
        force_en = 1'b0;
        @(negedge clk);
        total++;
        if (hl !== ~(4'b0001 << r)) begin bad++; $display("FAIL glitch_hold_row got=%b expected=%b", hl, ~(4'b0001 << r)); end
        repeat (2) @(negedge clk);
        total++;
        if (hl !== ~(4'b0001 << ((r + 1) % 4))) begin
            bad++; $display("FAIL glitch_next_row got=%b expected=%b", hl, ~(4'b0001 << ((r + 1) % 4)));
        end
        repeat (10) @(negedge clk);
    endtask

    task automatic test_two_keys;
        int prev;
        bit ok;
        prev = ev_cnt;
        exp_q.push_back(0);
        pressed[0] = 1'b1;
        pressed[2] = 1'b1;
        wait_event(prev, ok);
        total++; if (!ok) begin bad++; $display("FAIL two_keys_timeout got=none expected=event"); end
        repeat (3) @(negedge clk);
        pressed[0] = 1'b0;
        repeat (20) @(negedge clk);
        total++; if (ev_cnt !== prev + 1) begin bad++; $display("FAIL two_keys_count got=%0d expected=1", ev_cnt - prev); end
        total++; if (hl !== 4'b1110) begin bad++; $display("FAIL two_keys_held_hl got=%b expected=1110", hl); end
        pressed[2] = 1'b0;
        repeat (20) @(negedge clk);
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL two_keys_pending got=%0d expected=0", exp_q.size()); end
    endtask

    task automatic test_sequence;
        bit ok;
        logic [7:0] s;
        logic [7:0] e;
        for (int c = 1; c <= 5; c++) begin
            press_release(c, ok);
            total++; if (!ok) begin bad++; $display("FAIL seq_timeout key=%0d got=none expected=event", c); end
        end
        for (int i = 0; i < 4; i++) begin
            e = glyph[5 - i];
            get_seg(i, s, ok);
            total++; if (!ok || s !== e) begin bad++; $display("FAIL seq_seg digit=%0d got=%h expected=%h", i, s, e); end
        end
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            get_seg(i, s, ok);
            total++; if (!ok || s !== 8'hFF) begin bad++; $display("FAIL clr_seg digit=%0d got=%h expected=ff", i, s); end
        end
        press_release(0, ok);
        total++; if (!ok) begin bad++; $display("FAIL seq_timeout key=0 got=none expected=event"); end
        for (int i = 0; i < 4; i++) begin
            e = (i == 0) ? 8'hC0 : 8'hFF;
            get_seg(i, s, ok);
            total++; if (!ok || s !== e) begin bad++; $display("FAIL after_clr_seg digit=%0d got=%h expected=%h", i, s, e); end
        end
    endtask

    task automatic test_reset_mid;
        int prev;
        bit ok;
        bit found;
        logic [7:0] s;
        press_release(6, ok);
        total++; if (!ok) begin bad++; $display("FAIL mid_pre_timeout got=none expected=event"); end
        pressed[5] = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge clk);
            if (hl !== 4'b1101) found = 1'b1;
        end
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge clk);
            if (hl === 4'b1101) found = 1'b1;
        end
        total++; if (!found) begin bad++; $display("FAIL mid_row_sync got=%b expected=1101", hl); end
        repeat (5) @(negedge clk);
        rst = 1'b0;
        #1;
        total++; if (hl !== 4'b1110) begin bad++; $display("FAIL mid_rst_hl got=%b expected=1110", hl); end
        total++; if (key_code !== 4'd0) begin bad++; $display("FAIL mid_rst_code got=%0d expected=0", key_code); end
        total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_kv got=%b expected=0", key_valid); end
        total++; if (digit !== 4'b1110 || seg !== 8'hFF) begin
            bad++; $display("FAIL mid_rst_disp got=%b/%h expected=1110/ff", digit, seg);
        end
        prev = ev_cnt;
        exp_q.push_back(5);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        wait_event(prev, ok);
        total++; if (!ok) begin bad++; $display("FAIL mid_redebounce_timeout got=none expected=event"); end
        pressed[5] = 1'b0;
        repeat (20) @(negedge clk);
        total++; if (ev_cnt !== prev + 1) begin bad++; $display("FAIL mid_count got=%0d expected=1", ev_cnt - prev); end
        get_seg(0, s, ok);
        total++; if (!ok || s !== 8'h92) begin bad++; $display("FAIL mid_seg0 got=%h expected=92", s); end
        get_seg(1, s, ok);
        total++; if (!ok || s !== 8'hFF) begin bad++; $display("FAIL mid_seg1 got=%h expected=ff", s); end
    endtask

    initial begin
        test_reset();
        test_idle_scan();
        test_single_press();
        test_glitch();
        test_two_keys();
        test_sequence();
        test_reset_mid();
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL final_pending got=%0d expected=0", exp_q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
